// File: rtl/mb_cam_ctl_if.sv
// Bundle of request, read, status and CAM-side signals for the miss-buffer CAM controller.
// Optional multi-hit status (MB_CAM_CTL_MHIT_CHK_EN) adds mb_mhit_err and mb_mhit_sticky.
interface mb_cam_ctl_if #(
    parameter int NENT = 16
);
    logic            alloc_req;
    logic [39:0]     alloc_addr;
    logic            alloc_ack;
    logic            alloc_dup;
    logic [NENT-1:0] alloc_idx;

    logic            dealloc_vld;
    logic [NENT-1:0] dealloc_idx;

    logic            rd_req;
    logic [NENT-1:0] rd_idx;
    logic            rd_ack;
    logic            rd_vld;
    logic [39:0]     rd_data;

    logic            mb_full;
    logic            mb_almost_full;

    logic [NENT-1:0] cam_adr_w;
    logic [39:0]     cam_din;
    logic            cam_write_en;
    logic [NENT-1:0] cam_adr_r;
    logic            cam_read_en;
    logic            cam_lookup_en;
    logic [31:0]     cam_key;
    logic [NENT-1:0] cam_match;
    logic [39:0]     cam_dout;

`ifdef MB_CAM_CTL_MHIT_CHK_EN
    logic            mb_mhit_err;
    logic            mb_mhit_sticky;
`endif

    // Requester plus CAM array side: drives requests and CAM results.
    modport master (
        output alloc_req, alloc_addr, dealloc_vld, dealloc_idx, rd_req, rd_idx,
        output cam_match, cam_dout,
        input  alloc_ack, alloc_dup, alloc_idx, rd_ack, rd_vld, rd_data,
        input  mb_full, mb_almost_full,
        input  cam_adr_w, cam_din, cam_write_en, cam_adr_r, cam_read_en,
        input  cam_lookup_en, cam_key
`ifdef MB_CAM_CTL_MHIT_CHK_EN
        , input mb_mhit_err, mb_mhit_sticky
`endif
    );

    modport slave (
        input  alloc_req, alloc_addr, dealloc_vld, dealloc_idx, rd_req, rd_idx,
        input  cam_match, cam_dout,
        output alloc_ack, alloc_dup, alloc_idx, rd_ack, rd_vld, rd_data,
        output mb_full, mb_almost_full,
        output cam_adr_w, cam_din, cam_write_en, cam_adr_r, cam_read_en,
        output cam_lookup_en, cam_key
`ifdef MB_CAM_CTL_MHIT_CHK_EN
        , output mb_mhit_err, mb_mhit_sticky
`endif
    );
endinterface

// File: rtl/mb_cam_ctl.sv
// Allocation/read sequencer for the 16x40 miss-buffer CAM: duplicate check, free list, read arbitration.
// Define MB_CAM_CTL_MHIT_CHK_EN to add multi-hit error pulse and sticky status outputs.
module mb_cam_ctl #(
    parameter int NENT    = 16,
    parameter int FULL_WM = 2
) (
    input  logic         rclk,
    input  logic         rst,
    mb_cam_ctl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        LKUP,
        CHK,
        WR
    } state_t;

    function automatic logic [NENT-1:0] lowest_one(input logic [NENT-1:0] v);
        return v & (~v + {{(NENT-1){1'b0}}, 1'b1});
    endfunction

    state_t          state_q, state_d;
    logic [NENT-1:0] valid_q, valid_d;
    logic [NENT-1:0] wr_ent_q, wr_ent_d;

    logic            alloc_ack_q, alloc_ack_d;
    logic            alloc_dup_q, alloc_dup_d;
    logic [NENT-1:0] alloc_idx_q, alloc_idx_d;

    logic            rd_ack_q, rd_ack_d;
    logic            rd_p1_q, rd_p1_d;
    logic            rd_vld_q, rd_vld_d;
    logic [39:0]     rd_data_q, rd_data_d;

    logic            mb_full_q, mb_full_d;
    logic            mb_almost_full_q, mb_almost_full_d;

    logic [NENT-1:0] cam_adr_w_q, cam_adr_w_d;
    logic [39:0]     cam_din_q, cam_din_d;
    logic            cam_write_en_q, cam_write_en_d;
    logic [NENT-1:0] cam_adr_r_q, cam_adr_r_d;
    logic            cam_read_en_q, cam_read_en_d;
    logic            cam_lookup_en_q, cam_lookup_en_d;
    logic [31:0]     cam_key_q, cam_key_d;

`ifdef MB_CAM_CTL_MHIT_CHK_EN
    logic            mhit_err_q, mhit_err_d;
    logic            mhit_sticky_q, mhit_sticky_d;
`endif

    logic [NENT-1:0] hit;
    logic [NENT-1:0] hit_low;
    logic [NENT-1:0] free_low;
    logic [NENT-1:0] dealloc_mask;
    logic            rd_issue;

    always_comb begin
        hit          = bus.cam_match & valid_q;
        hit_low      = lowest_one(hit);
        free_low     = lowest_one(~valid_q);
        dealloc_mask = bus.dealloc_vld ? bus.dealloc_idx : '0;

        state_d         = state_q;
        wr_ent_d        = wr_ent_q;
        valid_d         = valid_q & ~dealloc_mask;
        alloc_ack_d     = 1'b0;
        alloc_dup_d     = 1'b0;
        alloc_idx_d     = '0;
        cam_lookup_en_d = 1'b0;
        cam_key_d       = '0;
        cam_write_en_d  = 1'b0;
        cam_adr_w_d     = '0;
        cam_din_d       = '0;

        // The ack register blocks a restart while a duplicate ack is still visible.
        unique case (state_q)
            IDLE: begin
                if (bus.alloc_req && !mb_full_q && !alloc_ack_q) begin
                    state_d         = LKUP;
                    cam_lookup_en_d = 1'b1;
                    cam_key_d       = bus.alloc_addr[39:8];
                end
            end
            LKUP: begin
                state_d = CHK;
            end
            CHK: begin
                alloc_ack_d = 1'b1;
                if (|hit) begin
                    alloc_dup_d = 1'b1;
                    alloc_idx_d = hit_low;
                    state_d     = IDLE;
                end else begin
                    wr_ent_d       = free_low;
                    alloc_idx_d    = free_low;
                    cam_write_en_d = 1'b1;
                    cam_adr_w_d    = free_low;
                    cam_din_d      = bus.alloc_addr;
                    state_d        = WR;
                end
            end
            WR: begin
                valid_d = valid_d | wr_ent_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A read is issued only into a cycle that carries no CAM write.
        rd_issue      = bus.rd_req && (state_d != WR);
        rd_ack_d      = rd_issue;
        cam_read_en_d = rd_issue;
        cam_adr_r_d   = rd_issue ? bus.rd_idx : '0;

        rd_p1_d   = cam_read_en_q;
        rd_vld_d  = rd_p1_q;
        rd_data_d = rd_p1_q ? bus.cam_dout : rd_data_q;

        mb_full_d        = &valid_d;
        mb_almost_full_d = ($countones(~valid_d) <= FULL_WM);

`ifdef MB_CAM_CTL_MHIT_CHK_EN
        mhit_err_d    = (state_q == CHK) && ($countones(hit) > 1);
        mhit_sticky_d = mhit_sticky_q | mhit_err_d;
`endif
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            valid_q          <= '0;
            wr_ent_q         <= '0;
            alloc_ack_q      <= 1'b0;
            alloc_dup_q      <= 1'b0;
            alloc_idx_q      <= '0;
            rd_ack_q         <= 1'b0;
            rd_p1_q          <= 1'b0;
            rd_vld_q         <= 1'b0;
            rd_data_q        <= '0;
            mb_full_q        <= 1'b0;
            mb_almost_full_q <= 1'b0;
            cam_adr_w_q      <= '0;
            cam_din_q        <= '0;
            cam_write_en_q   <= 1'b0;
            cam_adr_r_q      <= '0;
            cam_read_en_q    <= 1'b0;
            cam_lookup_en_q  <= 1'b0;
            cam_key_q        <= '0;
`ifdef MB_CAM_CTL_MHIT_CHK_EN
            mhit_err_q       <= 1'b0;
            mhit_sticky_q    <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            valid_q          <= valid_d;
            wr_ent_q         <= wr_ent_d;
            alloc_ack_q      <= alloc_ack_d;
            alloc_dup_q      <= alloc_dup_d;
            alloc_idx_q      <= alloc_idx_d;
            rd_ack_q         <= rd_ack_d;
            rd_p1_q          <= rd_p1_d;
            rd_vld_q         <= rd_vld_d;
            rd_data_q        <= rd_data_d;
            mb_full_q        <= mb_full_d;
            mb_almost_full_q <= mb_almost_full_d;
            cam_adr_w_q      <= cam_adr_w_d;
            cam_din_q        <= cam_din_d;
            cam_write_en_q   <= cam_write_en_d;
            cam_adr_r_q      <= cam_adr_r_d;
            cam_read_en_q    <= cam_read_en_d;
            cam_lookup_en_q  <= cam_lookup_en_d;
            cam_key_q        <= cam_key_d;
`ifdef MB_CAM_CTL_MHIT_CHK_EN
            mhit_err_q       <= mhit_err_d;
            mhit_sticky_q    <= mhit_sticky_d;
`endif
        end
    end

    assign bus.alloc_ack      = alloc_ack_q;
    assign bus.alloc_dup      = alloc_dup_q;
    assign bus.alloc_idx      = alloc_idx_q;
    assign bus.rd_ack         = rd_ack_q;
    assign bus.rd_vld         = rd_vld_q;
    assign bus.rd_data        = rd_data_q;
    assign bus.mb_full        = mb_full_q;
    assign bus.mb_almost_full = mb_almost_full_q;
    assign bus.cam_adr_w      = cam_adr_w_q;
    assign bus.cam_din        = cam_din_q;
    assign bus.cam_write_en   = cam_write_en_q;
    assign bus.cam_adr_r      = cam_adr_r_q;
    assign bus.cam_read_en    = cam_read_en_q;
    assign bus.cam_lookup_en  = cam_lookup_en_q;
    assign bus.cam_key        = cam_key_q;
`ifdef MB_CAM_CTL_MHIT_CHK_EN
    assign bus.mb_mhit_err    = mhit_err_q;
    assign bus.mb_mhit_sticky = mhit_sticky_q;
`endif

endmodule

// File: tb/tb_mb_cam_ctl.sv
// Directed testbench for mb_cam_ctl with a small behavioural CAM responder.
module tb_mb_cam_ctl;

    localparam int NENT = 16;

    logic rclk = 1'b0;
    logic rst  = 1'b1;

    always #5 rclk = ~rclk;

    mb_cam_ctl_if #(.NENT(NENT)) bus ();

    mb_cam_ctl #(.NENT(NENT), .FULL_WM(2)) dut (
        .rclk (rclk),
        .rst  (rst),
        .bus  (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    logic            force_en  = 1'b0;
    logic [NENT-1:0] force_val = '0;

    logic [39:0]     cam_mem [NENT];
    logic [NENT-1:0] cam_written = '0;

    // CAM responder: match and read data appear in the cycle after issue; stale contents are kept.
    always @(posedge rclk) begin : cam_model
        logic            lk, rd, wr;
        logic [31:0]     key;
        logic [NENT-1:0] ra, wa, m;
        logic [39:0]     wd, d;
        lk  = bus.cam_lookup_en;
        key = bus.cam_key;
        rd  = bus.cam_read_en;
        ra  = bus.cam_adr_r;
        wr  = bus.cam_write_en;
        wa  = bus.cam_adr_w;
        wd  = bus.cam_din;
        #1;
        m = '0;
        d = '0;
        for (int j = 0; j < NENT; j++) begin
            if (lk && cam_written[j] && (cam_mem[j][39:8] == key)) m[j] = 1'b1;
            if (rd && ra[j]) d = cam_mem[j];
        end
        if (lk && force_en) m = force_val;
        for (int j = 0; j < NENT; j++) begin
            if (wr && wa[j]) begin
                cam_mem[j]     = wd;
                cam_written[j] = 1'b1;
            end
        end
        bus.cam_match = m;
        bus.cam_dout  = d;
    end

    task automatic tick;
        @(posedge rclk);
        #1;
    endtask

    task automatic applyStimulus(input logic areq, input logic [39:0] aaddr,
                                 input logic dvld, input logic [NENT-1:0] didx,
                                 input logic rreq, input logic [NENT-1:0] ridx);
        bus.alloc_req   = areq;
        bus.alloc_addr  = aaddr;
        bus.dealloc_vld = dvld;
        bus.dealloc_idx = didx;
        bus.rd_req      = rreq;
        bus.rd_idx      = ridx;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic resetCheck(input string tag);
        checkOutput({tag, "_alloc_ack"},  bus.alloc_ack, 0);
        checkOutput({tag, "_alloc_dup"},  bus.alloc_dup, 0);
        checkOutput({tag, "_alloc_idx"},  bus.alloc_idx, 0);
        checkOutput({tag, "_rd_ack"},     bus.rd_ack, 0);
        checkOutput({tag, "_rd_vld"},     bus.rd_vld, 0);
        checkOutput({tag, "_rd_data"},    bus.rd_data, 0);
        checkOutput({tag, "_full"},       bus.mb_full, 0);
        checkOutput({tag, "_afull"},      bus.mb_almost_full, 0);
        checkOutput({tag, "_adr_w"},      bus.cam_adr_w, 0);
        checkOutput({tag, "_din"},        bus.cam_din, 0);
        checkOutput({tag, "_wen"},        bus.cam_write_en, 0);
        checkOutput({tag, "_adr_r"},      bus.cam_adr_r, 0);
        checkOutput({tag, "_ren"},        bus.cam_read_en, 0);
        checkOutput({tag, "_lkup"},       bus.cam_lookup_en, 0);
        checkOutput({tag, "_key"},        bus.cam_key, 0);
    endtask

    // Full alloc handshake: lookup in cycle 1, decision in cycle 2, ack (and write) in cycle 3.
    task automatic allocCheck(input string tag, input logic [39:0] addr,
                              input logic [NENT-1:0] exp_idx, input logic exp_dup,
                              input logic [NENT-1:0] dmask);
        applyStimulus(1'b1, addr, 1'b0, '0, 1'b0, '0);
        tick;
        checkOutput({tag, "_lkup"}, bus.cam_lookup_en, 1);
        checkOutput({tag, "_key"},  bus.cam_key, addr[39:8]);
        checkOutput({tag, "_wen1"}, bus.cam_write_en, 0);
        tick;
        checkOutput({tag, "_lkup2"}, bus.cam_lookup_en, 0);
        checkOutput({tag, "_ack2"},  bus.alloc_ack, 0);
        checkOutput({tag, "_wen2"},  bus.cam_write_en, 0);
        tick;
        checkOutput({tag, "_ack"},   bus.alloc_ack, 1);
        checkOutput({tag, "_dup"},   bus.alloc_dup, exp_dup);
        checkOutput({tag, "_idx"},   bus.alloc_idx, exp_idx);
        checkOutput({tag, "_wen3"},  bus.cam_write_en, !exp_dup);
        checkOutput({tag, "_adr_w"}, bus.cam_adr_w, exp_dup ? '0 : exp_idx);
        checkOutput({tag, "_din"},   bus.cam_din, exp_dup ? 40'h0 : addr);
        applyStimulus(1'b0, addr, dmask != '0, dmask, 1'b0, '0);
        tick;
        applyStimulus(1'b0, addr, 1'b0, '0, 1'b0, '0);
        checkOutput({tag, "_ack4"}, bus.alloc_ack, 0);
        checkOutput({tag, "_wen4"}, bus.cam_write_en, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : stimulus
        logic [39:0]     addr_a, addr_b, addr_c, addr_d, addr_e, addr_x, addr_mh, addr_f;
        logic [NENT-1:0] one_hot;
        int              seen, n;

        addr_a  = 40'h12_3456_7800;
        addr_b  = 40'hAB_CDEF_0100;
        addr_c  = 40'h55_AA55_AA00;
        addr_d  = 40'h0F_0F0F_0F00;
        addr_e  = 40'hEE_0000_1100;
        addr_x  = 40'h77_6655_4400;
        addr_mh = 40'h99_8877_6600;

        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
        rst = 1'b1;
        repeat (2) @(posedge rclk);
        #1;
        resetCheck("reset");
        rst = 1'b0;
        tick;

        $display("[TB] first allocation and duplicate");
        allocCheck("alloc_a", addr_a, 16'h0001, 1'b0, '0);
        allocCheck("dup_a",   addr_a, 16'h0001, 1'b1, '0);

        $display("[TB] dealloc of entry 0 coinciding with write of entry 1");
        allocCheck("alloc_b_dealloc0", addr_b, 16'h0002, 1'b0, 16'h0001);
        allocCheck("realloc_a_stale",  addr_a, 16'h0001, 1'b0, '0);

        $display("[TB] multi-hit resolves to lowest entry");
        force_en  = 1'b1;
        force_val = 16'h0003;
        allocCheck("mhit", addr_mh, 16'h0001, 1'b1, '0);
        force_en  = 1'b0;

        allocCheck("alloc_c", addr_c, 16'h0004, 1'b0, '0);

        $display("[TB] read held across the write cycle");
        applyStimulus(1'b1, addr_d, 1'b0, '0, 1'b0, '0);
        tick;
        tick;
        applyStimulus(1'b1, addr_d, 1'b0, '0, 1'b1, 16'h0004);
        tick;
        checkOutput("rdwr_wen",    bus.cam_write_en, 1);
        checkOutput("rdwr_idx",    bus.alloc_idx, 16'h0008);
        checkOutput("rdwr_rd_ack", bus.rd_ack, 0);
        checkOutput("rdwr_ren",    bus.cam_read_en, 0);
        applyStimulus(1'b0, addr_d, 1'b0, '0, 1'b1, 16'h0004);
        tick;
        checkOutput("rdwr_rd_ack2", bus.rd_ack, 1);
        checkOutput("rdwr_ren2",    bus.cam_read_en, 1);
        checkOutput("rdwr_adr_r",   bus.cam_adr_r, 16'h0004);
        checkOutput("rdwr_wen2",    bus.cam_write_en, 0);
        applyStimulus(1'b0, addr_d, 1'b0, '0, 1'b0, '0);
        tick;
        checkOutput("rdwr_ren3",   bus.cam_read_en, 0);
        checkOutput("rdwr_adr_r3", bus.cam_adr_r, 0);
        checkOutput("rdwr_vld3",   bus.rd_vld, 0);
        tick;
        checkOutput("rdwr_vld4",   bus.rd_vld, 1);
        checkOutput("rdwr_data4",  bus.rd_data, addr_c);
        tick;
        checkOutput("rdwr_vld5",   bus.rd_vld, 0);

        $display("[TB] back-to-back reads");
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 16'h0001);
        tick;
        checkOutput("b2b_ack0", bus.rd_ack, 1);
        checkOutput("b2b_adr0", bus.cam_adr_r, 16'h0001);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 16'h0004);
        tick;
        checkOutput("b2b_ack1", bus.rd_ack, 1);
        checkOutput("b2b_adr1", bus.cam_adr_r, 16'h0004);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
        tick;
        checkOutput("b2b_vld0",  bus.rd_vld, 1);
        checkOutput("b2b_data0", bus.rd_data, addr_a);
        tick;
        checkOutput("b2b_vld1",  bus.rd_vld, 1);
        checkOutput("b2b_data1", bus.rd_data, addr_c);
        tick;
        checkOutput("b2b_vld2",  bus.rd_vld, 0);

        $display("[TB] fill to full");
        for (int i = 4; i < NENT; i++) begin
            addr_f  = 40'hC0_0000_0000 | (40'(i) << 8);
            one_hot = 16'(1) << i;
            allocCheck($sformatf("fill%0d", i), addr_f, one_hot, 1'b0, '0);
            checkOutput($sformatf("fill%0d_afull", i), bus.mb_almost_full, (i + 1) >= 14);
            checkOutput($sformatf("fill%0d_full", i),  bus.mb_full, (i + 1) == 16);
        end

        $display("[TB] request while full, then free entry 8");
        applyStimulus(1'b1, addr_e, 1'b0, '0, 1'b0, '0);
        seen = 0;
        repeat (6) begin
            tick;
            if (bus.alloc_ack || bus.cam_lookup_en) seen++;
        end
        checkOutput("full_no_ack", seen, 0);
        applyStimulus(1'b1, addr_e, 1'b1, 16'h0100, 1'b0, '0);
        tick;
        applyStimulus(1'b1, addr_e, 1'b0, '0, 1'b0, '0);
        checkOutput("freed_full",  bus.mb_full, 0);
        checkOutput("freed_afull", bus.mb_almost_full, 1);
        n = 0;
        while (!bus.alloc_ack && n < 8) begin
            tick;
            n++;
        end
        checkOutput("alloc17_ack",   bus.alloc_ack, 1);
        checkOutput("alloc17_dup",   bus.alloc_dup, 0);
        checkOutput("alloc17_idx",   bus.alloc_idx, 16'h0100);
        checkOutput("alloc17_adr_w", bus.cam_adr_w, 16'h0100);
        checkOutput("alloc17_din",   bus.cam_din, addr_e);
        applyStimulus(1'b0, addr_e, 1'b0, '0, 1'b0, '0);
        tick;
        checkOutput("alloc17_full", bus.mb_full, 1);

        $display("[TB] reset during the match-check cycle");
        applyStimulus(1'b0, '0, 1'b1, 16'h8000, 1'b0, '0);
        tick;
        applyStimulus(1'b0, '0, 1'b1, 16'h4000, 1'b0, '0);
        tick;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
        checkOutput("pre_rst_full",  bus.mb_full, 0);
        checkOutput("pre_rst_afull", bus.mb_almost_full, 1);
        applyStimulus(1'b1, addr_x, 1'b0, '0, 1'b0, '0);
        tick;
        applyStimulus(1'b1, addr_x, 1'b0, '0, 1'b1, 16'h0002);
        tick;
        checkOutput("chk_rd_ack", bus.rd_ack, 1);
        checkOutput("chk_ren",    bus.cam_read_en, 1);
        #2;
        rst = 1'b1;
        #1;
        resetCheck("rst_chk");
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
        @(posedge rclk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            tick;
            if (bus.alloc_ack || bus.cam_lookup_en || bus.rd_vld) seen++;
        end
        checkOutput("post_rst_quiet", seen, 0);
        allocCheck("post_rst_a", addr_a, 16'h0001, 1'b0, '0);
        checkOutput("post_rst_afull", bus.mb_almost_full, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
